// File: rtl/muldiv_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_pkg
// Brief    : Op codes, state encodings and decode helpers for muldiv_iter.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_iter_pkg;

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
               (op == c_OP_DIV)  || (op == c_OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_negate
// Brief    : Conditional two's-complement negation of a WIDTH-bit value.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Brief    : Iterative RV32M/RV64M multiply/divide unit with tag and annul.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             annul_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int c_MUL_CYC = XLEN / MUL_STEP;
    localparam int c_CNT_W   = $clog2(XLEN);

    logic [1:0]          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b;
    logic [2:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic                r_neg_p, r_neg_q, r_neg_r;

    logic                w_sa, w_sb, w_accept, w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_quo, w_rem, w_result;
    logic [2*XLEN-1:0]   w_prod, w_mul_nxt, w_div_nxt;
    logic [XLEN+MUL_STEP-1:0] w_pp, w_sum;
    logic [XLEN:0]       w_part, w_diff;

    assign ready_o  = (r_state == c_ST_IDLE) & ~rst;
    assign busy_o   = (r_state != c_ST_IDLE) & ~rst;
    assign w_accept = start_i & ready_o & ~annul_i;

    assign w_sa      = is_signed_a(op_i) & a_i[XLEN-1];
    assign w_sb      = is_signed_b(op_i) & b_i[XLEN-1];
    assign w_b_zero  = (b_i == '0);
    assign w_ovf     = is_signed_a(op_i) & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
    assign w_special = is_div(op_i) & (w_b_zero | w_ovf);

    muldiv_negate #(.WIDTH(XLEN)) u_abs_a (.i_val(a_i), .i_neg(w_sa), .o_val(w_abs_a));
    muldiv_negate #(.WIDTH(XLEN)) u_abs_b (.i_val(b_i), .i_neg(w_sb), .o_val(w_abs_b));

    // Multiply: the low half of r_acc holds the remaining multiplier bits and
    // shifts out MUL_STEP bits per cycle while partial sums enter at the top.
    assign w_pp      = {{MUL_STEP{1'b0}}, r_b} * {{XLEN{1'b0}}, r_acc[MUL_STEP-1:0]};
    assign w_sum     = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:MUL_STEP]};

    // Restoring divide: r_acc = {remainder, dividend/quotient}.
    assign w_part    = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_part - {1'b0, r_b};
    assign w_div_nxt = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    muldiv_negate #(.WIDTH(2*XLEN)) u_fix_p (.i_val(r_acc), .i_neg(r_neg_p), .o_val(w_prod));
    muldiv_negate #(.WIDTH(XLEN)) u_fix_q (.i_val(r_acc[XLEN-1:0]), .i_neg(r_neg_q), .o_val(w_quo));
    muldiv_negate #(.WIDTH(XLEN)) u_fix_r (.i_val(r_acc[2*XLEN-1:XLEN]), .i_neg(r_neg_r), .o_val(w_rem));

    always_comb begin
        w_result = w_quo;
        if (r_op == c_OP_MUL)
            w_result = w_prod[XLEN-1:0];
        else if (!r_op[2])
            w_result = w_prod[2*XLEN-1:XLEN];
        else if (r_op[1])
            w_result = w_rem;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_special)
                        w_state_nxt = c_ST_FIX;
                    else if (is_div(op_i))
                        w_state_nxt = c_ST_DIV;
                    else
                        w_state_nxt = c_ST_MUL;
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (annul_i)
                    w_state_nxt = c_ST_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = c_ST_FIX;
            end
            c_ST_FIX: w_state_nxt = c_ST_IDLE;
            default:  w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= c_OP_MUL;
            r_tag    <= '0;
            r_neg_p  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        r_tag   <= tag_i;
                        r_b     <= w_abs_b;
                        r_neg_p <= w_sa ^ w_sb;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_cnt   <= is_div(op_i) ? c_CNT_W'(XLEN - 1) : c_CNT_W'(c_MUL_CYC - 1);
                        r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                        // Special cases preload the final raw result with no fixup.
                        if (w_special) begin
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_acc   <= w_b_zero ? {a_i, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_i};
                        end
                    end
                end
                c_ST_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_ST_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_ST_FIX: begin
                    if (!annul_i) begin
                        done_o   <= 1'b1;
                        result_o <= w_result;
                        tag_o    <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Brief    : Directed scoreboard bench for muldiv_iter (XLEN=32, MUL_STEP=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  tag_i = '0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  tag_o;

    muldiv_iter #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i),
        .b_i(b_i), .tag_i(tag_i), .annul_i(annul_i), .ready_o(ready_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result %h tag %h expected no done", result_o, tag_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result_o, e.res);
                check("tag", 32'(tag_o), 32'(e.tag));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200 && ready_o !== 1'b1; i++) @(negedge clk);
        if (ready_o !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got ready_o %b expected 1", ready_o);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        tag_i   = tag;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat,
                         input bit push);
        wait_ready();
        drive(op, a, b, tag);
        if (push) sb_q.push_back('{exp, tag, cyc + lat});
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        tag_i   = 5'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_done",   32'(done_o),   32'd0);
        check("rst_result", result_o,      32'd0);
        check("rst_tag",    32'(tag_o),    32'd0);
        check("rst_ready",  32'(ready_o),  32'd0);
        check("rst_busy",   32'(busy_o),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_o), 32'd1);
        check("post_rst_busy",  32'(busy_o),  32'd0);

        issue(c_OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 10, 1'b1);
        issue(c_OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 10, 1'b1);
        issue(c_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 10, 1'b1);
        issue(c_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 10, 1'b1);
        issue(c_OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34, 1'b1);
        issue(c_OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 34, 1'b1);
        issue(c_OP_DIVU,   32'd100,        32'd7,         5'd6,  32'd14,        34, 1'b1);
        issue(c_OP_REMU,   32'd100,        32'd7,         5'd7,  32'd2,         34, 1'b1);
        issue(c_OP_DIVU,   32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 2,  1'b1);
        issue(c_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2,  1'b1);
        issue(c_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         2,  1'b1);
        issue(c_OP_REM,    32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFF9, 2,  1'b1);
        issue(c_OP_REM,    32'd5,          32'd0,         5'd10, 32'd5,         2,  1'b1);

        // Flush: annul a DIV on its tenth cycle; no done may follow.
        issue(c_OP_DIV, 32'd1000, 32'd3, 5'd13, 32'd0, 34, 1'b0);
        repeat (8) @(negedge clk);
        check("busy_before_annul", 32'(busy_o), 32'd1);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_ready",       32'(ready_o), 32'd1);
        check("annul_hold_result", result_o,     32'd5);
        check("annul_hold_tag",    32'(tag_o),   32'd10);

        // MUL 3x4 with start_i held (and inputs scrambled) while busy.
        wait_ready();
        drive(c_OP_MUL, 32'd3, 32'd4, 5'd14);
        sb_q.push_back('{32'd12, 5'd14, cyc + 10});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_while_held", 32'(busy_o), 32'd1);
            op_i  = c_OP_DIVU;
            a_i   = 32'd99 + 32'(i);
            b_i   = 32'd0;
            tag_i = 5'd31;
        end
        start_i = 1'b0;

        // Reset in the middle of a DIV.
        issue(c_OP_DIV, 32'd50, 32'd5, 5'd15, 32'd0, 34, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_done",   32'(done_o),  32'd0);
        check("midrst_result", result_o,     32'd0);
        check("midrst_tag",    32'(tag_o),   32'd0);
        check("midrst_ready",  32'(ready_o), 32'd0);
        check("midrst_busy",   32'(busy_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_midrst_ready", 32'(ready_o), 32'd1);

        // Back-to-back: second start presented in the done cycle of the first.
        issue(c_OP_DIVU, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 2, 1'b1);
        wait_ready();
        check("b2b_in_done_cycle", 32'(done_o), 32'd1);
        issue(c_OP_MUL, 32'h1234_5678, 32'h10, 5'd17, 32'h2345_6780, 10, 1'b1);

        repeat (50) @(negedge clk);
        check("pending_responses", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Executes all eight RV32M/RV64M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Start/ready/done handshake with annul and a tag carried through; this replaces the divide-only start/ready interface.
- EX holds stallreq while busy_o is high and takes result_o and tag_o on done_o.

Parameters:
- XLEN, 32, operand and result width; must be a power of two, at least 8.
- MUL_STEP, 4, multiplier bits retired per cycle; must divide XLEN.
- TAG_W, 5, width of the destination-register tag carried with the operation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- start_i  in  1  request; accepted on a rising edge where start_i & ready_o & ~annul_i.
- op_i  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- tag_i  in  TAG_W  destination tag.
- annul_i  in  1  abort the in-flight operation (flush).
- ready_o  out  1  idle, can accept.
- busy_o  out  1  operation in flight; equals ~ready_o outside reset.
- done_o  out  1  one-cycle pulse, result valid.
- result_o  out  XLEN  selected result.
- tag_o  out  TAG_W  tag of the completed operation.

Behaviour:
- Reset: while rst is high, state becomes IDLE. done_o=0, result_o=0, tag_o=0, busy_o=0 and ready_o=0. ready_o=1 from the first cycle after rst falls.
- States:
  - IDLE: ready_o=1.
  - MUL: XLEN/MUL_STEP cycles.
  - DIV: XLEN cycles.
  - FIX: 1 cycle of sign fixup and result select.
- Accept (IDLE):
  - Latch op, tag and operand magnitudes.
  - Signedness: a is signed for MULH, MULHSU, DIV and REM. b is signed for MULH, DIV and REM. MUL uses the unsigned path; only the low word is used.
  - Compute negate flags. Go to MUL or DIV.
  - Special cases go straight to FIX:
    - Divide by zero (b=0): quotient = all ones, remainder = a.
    - Signed overflow (a = -2^(XLEN-1), b = -1, DIV/REM): quotient = a, remainder = 0.
- MUL datapath:
  - Unsigned shift-add of |a| × |b|, MUL_STEP bits per cycle, into a 2*XLEN accumulator.
  - In FIX, negate the 2*XLEN product if the operand signs differ (signed operands only).
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- DIV datapath:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - In FIX, negate the quotient if the signs differ and the divisor is nonzero. The remainder takes the sign of the dividend.
- Latency: done_o is high exactly L cycles after the accepting edge.
  - MUL family: L = XLEN/MUL_STEP + 2; 10 for the defaults.
  - DIV/REM: L = XLEN + 2; 34 for the defaults.
  - Special cases: L = 2.
- Done cycle: FIX registers result_o, tag_o and done_o and returns to IDLE. done_o is therefore high in an IDLE cycle with ready_o=1, so a back-to-back start in the done cycle is accepted.
- Hold: result_o and tag_o hold until the next done.
- start_i while busy: ignored, with no side effects.
- annul_i in MUL, DIV or FIX:
  - Next state is IDLE and no done_o is produced.
  - result_o and tag_o keep their previous values.
  - annul_i in IDLE blocks acceptance that cycle.
  - annul_i in the done cycle does not retract the pulse.
- rst mid-operation: same effect as annul, plus outputs cleared.
- Operands are sampled only at accept; a_i and b_i may change afterwards.

Decomposition:
- Add to defines.v:
  - funct3 op codes (MULDIV_MUL … MULDIV_REMU).
  - State encodings (2 bits).
  - Helper macros for is_div and is_signed_a/b.
- One optional combinational sub-module, muldiv_negate (conditional two's-complement, parametrised width), instanced for the operand magnitudes and the FIX-stage fixups.
- Everything else stays in muldiv_iter.

Test Plan (XLEN=32, MUL_STEP=4):
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB, done exactly 10 cycles after accept, tag_o echoes tag_i=5'd9.
- High-word multiplies, one per op:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, each with done at 34 cycles; DIVU 100/7 → 14 and REMU → 2.
- Special cases, each with done at 2 cycles:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush and stall:
  - Start DIV, then assert annul_i on cycle 10 → no done_o, ready_o=1 next cycle.
  - Then start MUL 3×4 → 12 at 10 cycles.
  - start_i held during busy → ignored.
- rst asserted mid-DIV → outputs 0 and ready_o=0 during rst, ready_o=1 after.
- Back-to-back: a new start in a done cycle → accepted, correct second result.
